bp_me_mem_arbiter: RTL and testbench

// - Shares one bp_mem instance among num_cce_p CCEs. It replaces the per-CCE bp_mem replication in the ME top level.
// - Round-robin arbitrates the mem_cmd (read) and mem_data_cmd (write) channels independently.
// - Records the winner's CCE id per channel in an in-order tag FIFO.
// - Steers mem_data_resp and mem_resp back to the CCE at the head of the matching FIFO.

---
 rtl/bp_me_mem_arbiter_pkg.sv | 36 +++
 rtl/bp_me_mem_arbiter_rr_lock_arb.sv | 88 ++++++++
 rtl/bp_me_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bp_me_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_mem_arbiter_pkg.sv
// Shared types and width helpers for the memory-side arbiter.
//   arb_state_e  : lock state of a command-channel round-robin arbiter
//   safe_clog2   : clog2 that never returns 0, so a single-entry index is 1 bit wide
//   *_width      : flat message widths (type | lce id | way id | address [| block data])
package bp_me_mem_arbiter_pkg;

  typedef enum logic {
    e_arb_open   = 1'b0,
    e_arb_locked = 1'b1
  } arb_state_e;

  localparam int msg_type_width_lp = 3;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cmd_width(input int num_lce, input int addr_width, input int lce_assoc);
    return msg_type_width_lp + safe_clog2(num_lce) + safe_clog2(lce_assoc) + addr_width;
  endfunction

  function automatic int data_cmd_width(input int num_lce, input int addr_width,
                                        input int lce_assoc, input int block_bytes);
    return cmd_width(num_lce, addr_width, lce_assoc) + 8 * block_bytes;
  endfunction

  function automatic int resp_width(input int num_lce, input int addr_width, input int lce_assoc);
    return msg_type_width_lp + safe_clog2(num_lce) + safe_clog2(lce_assoc) + addr_width;
  endfunction

  function automatic int data_resp_width(input int num_lce, input int addr_width,
                                         input int lce_assoc, input int block_bytes);
    return resp_width(num_lce, addr_width, lce_assoc) + 8 * block_bytes;
  endfunction

endpackage

// File: rtl/bp_me_mem_arbiter_rr_lock_arb.sv
// bp_me_rr_lock_arb: round-robin grant with a lock that holds a stalled grant.
//   req_i      : requesters eligible this cycle
//   yumi_i     : downstream consumed the granted command
//   grant_v_o  : a grant is being presented
//   grant_id_o : index of the granted requester
//
// state        | meaning
// e_arb_open   | grant follows the round-robin search from ptr_q
// e_arb_locked | a grant was presented without yumi; it is held until yumi
module bp_me_rr_lock_arb
  import bp_me_mem_arbiter_pkg::*;
#(
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_req_p-1:0]     req_i,
  input  logic                     yumi_i,
  output logic                     grant_v_o,
  output logic [lg_num_req_lp-1:0] grant_id_o
);

  typedef logic [lg_num_req_lp-1:0] id_t;
  typedef logic [lg_num_req_lp:0]   cand_t;

  arb_state_e state_q, state_d;
  id_t        ptr_q, ptr_d;
  id_t        lock_id_q, lock_id_d;
  id_t        rr_id;
  logic       rr_v;
  cand_t      cand;

  // Walk offsets from the highest down so the smallest offset from ptr_q wins.
  always_comb begin
    rr_v  = 1'b0;
    rr_id = '0;
    cand  = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = cand_t'(ptr_q) + cand_t'(i);
      if (cand >= cand_t'(num_req_p)) cand = cand - cand_t'(num_req_p);
      if (req_i[cand[lg_num_req_lp-1:0]]) begin
        rr_v  = 1'b1;
        rr_id = cand[lg_num_req_lp-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_id_d  = lock_id_q;
    grant_v_o  = 1'b0;
    grant_id_o = rr_id;
    case (state_q)
      e_arb_open: begin
        grant_v_o  = rr_v;
        grant_id_o = rr_id;
        if (rr_v && !yumi_i) begin
          state_d   = e_arb_locked;
          lock_id_d = rr_id;
        end
      end
      e_arb_locked: begin
        grant_v_o  = 1'b1;
        grant_id_o = lock_id_q;
        if (yumi_i) state_d = e_arb_open;
      end
      default: state_d = e_arb_open;
    endcase
    if (grant_v_o && yumi_i) begin
      ptr_d = (grant_id_o == id_t'(num_req_p - 1)) ? '0 : grant_id_o + id_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_arb_open;
      ptr_q     <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// bp_me_mem_arbiter: shares one memory among num_cce_p CCEs.
//   cce_mem_cmd_* / cce_mem_data_cmd_*   : read / write commands from each CCE (valid-yumi)
//   mem_cmd_* / mem_data_cmd_*           : granted command toward memory (valid-yumi)
//   mem_data_resp_* / mem_resp_*         : read data / write ack from memory (valid-ready)
//   cce_mem_data_resp_* / cce_mem_resp_* : responses broadcast to the CCEs, valid one-hot
// Each channel records winning CCE ids in an in-order tag FIFO; the FIFO head
// steers the matching response, since memory answers in issue order per channel.
module bp_me_mem_arbiter
  import bp_me_mem_arbiter_pkg::*;
#(
  parameter  int num_cce_p             = 2,
  parameter  int num_lce_p             = 1,
  parameter  int addr_width_p          = 22,
  parameter  int lce_assoc_p           = 8,
  parameter  int block_size_in_bytes_p = 64,
  parameter  int max_outstanding_p     = 4,
  localparam int lg_num_cce_lp         = safe_clog2(num_cce_p),
  localparam int cmd_w_lp       = cmd_width(num_lce_p, addr_width_p, lce_assoc_p),
  localparam int data_cmd_w_lp  = data_cmd_width(num_lce_p, addr_width_p, lce_assoc_p, block_size_in_bytes_p),
  localparam int resp_w_lp      = resp_width(num_lce_p, addr_width_p, lce_assoc_p),
  localparam int data_resp_w_lp = data_resp_width(num_lce_p, addr_width_p, lce_assoc_p, block_size_in_bytes_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,

  input  logic [num_cce_p-1:0][cmd_w_lp-1:0]        cce_mem_cmd_i,
  input  logic [num_cce_p-1:0]                      cce_mem_cmd_v_i,
  output logic [num_cce_p-1:0]                      cce_mem_cmd_yumi_o,
  input  logic [num_cce_p-1:0][data_cmd_w_lp-1:0]   cce_mem_data_cmd_i,
  input  logic [num_cce_p-1:0]                      cce_mem_data_cmd_v_i,
  output logic [num_cce_p-1:0]                      cce_mem_data_cmd_yumi_o,

  output logic [cmd_w_lp-1:0]                       mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_yumi_i,
  output logic [data_cmd_w_lp-1:0]                  mem_data_cmd_o,
  output logic                                      mem_data_cmd_v_o,
  input  logic                                      mem_data_cmd_yumi_i,

  input  logic [data_resp_w_lp-1:0]                 mem_data_resp_i,
  input  logic                                      mem_data_resp_v_i,
  output logic                                      mem_data_resp_ready_o,
  input  logic [resp_w_lp-1:0]                      mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_ready_o,

  output logic [num_cce_p-1:0][data_resp_w_lp-1:0]  cce_mem_data_resp_o,
  output logic [num_cce_p-1:0]                      cce_mem_data_resp_v_o,
  input  logic [num_cce_p-1:0]                      cce_mem_data_resp_ready_i,
  output logic [num_cce_p-1:0][resp_w_lp-1:0]       cce_mem_resp_o,
  output logic [num_cce_p-1:0]                      cce_mem_resp_v_o,
  input  logic [num_cce_p-1:0]                      cce_mem_resp_ready_i
);

  localparam int ptr_w_lp = safe_clog2(max_outstanding_p);
  localparam int cnt_w_lp = safe_clog2(max_outstanding_p + 1);

  // Channel 0 pairs read commands with data responses; channel 1 pairs
  // write commands with write acks.
  logic [1:0][num_cce_p-1:0]     ch_cmd_v, ch_cce_ready, ch_yumi_oh, ch_dest_v;
  logic [1:0]                    ch_mem_yumi, ch_resp_v, ch_grant_v, ch_resp_ready;
  logic [1:0][lg_num_cce_lp-1:0] ch_grant_id;

  assign ch_cmd_v[0]     = cce_mem_cmd_v_i;
  assign ch_cmd_v[1]     = cce_mem_data_cmd_v_i;
  assign ch_cce_ready[0] = cce_mem_data_resp_ready_i;
  assign ch_cce_ready[1] = cce_mem_resp_ready_i;
  assign ch_mem_yumi[0]  = mem_cmd_yumi_i;
  assign ch_mem_yumi[1]  = mem_data_cmd_yumi_i;
  assign ch_resp_v[0]    = mem_data_resp_v_i;
  assign ch_resp_v[1]    = mem_resp_v_i;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [cnt_w_lp-1:0]                           count_q, count_d;
    logic [ptr_w_lp-1:0]                           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [max_outstanding_p-1:0][lg_num_cce_lp-1:0] tag_q;
    logic [lg_num_cce_lp-1:0]                      head_id;
    logic [num_cce_p-1:0]                          req, yumi_oh, dest_v;
    logic                                          full, empty, push, pop, grant_v;
    logic [lg_num_cce_lp-1:0]                      grant_id;

    assign full  = (count_q == cnt_w_lp'(max_outstanding_p));
    assign empty = (count_q == '0);

    // Gating with reset_n_i keeps every valid/yumi output low while reset is held.
    assign req = ch_cmd_v[ch] & {num_cce_p{reset_n_i & ~full}};

    bp_me_rr_lock_arb #(.num_req_p(num_cce_p)) arb (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .req_i      (req),
      .yumi_i     (ch_mem_yumi[ch]),
      .grant_v_o  (grant_v),
      .grant_id_o (grant_id)
    );

    assign push    = grant_v & ch_mem_yumi[ch];
    assign head_id = tag_q[rptr_q];
    assign pop     = ch_resp_v[ch] & ch_resp_ready[ch];

    always_comb begin
      yumi_oh = '0;
      dest_v  = '0;
      if (push) yumi_oh[grant_id] = 1'b1;
      if (ch_resp_v[ch] && !empty) dest_v[head_id] = 1'b1;
    end

    always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (push) wptr_d = (wptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
      if (pop)  rptr_d = (rptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_w_lp'(1);
        2'b01:   count_d = count_q - cnt_w_lp'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        count_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        count_q <= count_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) tag_q[wptr_q] <= grant_id;
    end

    // A response with no outstanding tag is never acknowledged; flag it in simulation.
    always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
        assert (!(ch_resp_v[ch] && empty))
          else $warning("bp_me_mem_arbiter: response on channel %0d with no outstanding tag", ch);
      end
    end

    assign ch_grant_v[ch]    = grant_v;
    assign ch_grant_id[ch]   = grant_id;
    assign ch_yumi_oh[ch]    = yumi_oh;
    assign ch_dest_v[ch]     = dest_v;
    assign ch_resp_ready[ch] = ~empty & ch_cce_ready[ch][head_id];
  end

  assign mem_cmd_v_o             = ch_grant_v[0];
  assign mem_cmd_o               = cce_mem_cmd_i[ch_grant_id[0]];
  assign cce_mem_cmd_yumi_o      = ch_yumi_oh[0];
  assign mem_data_cmd_v_o        = ch_grant_v[1];
  assign mem_data_cmd_o          = cce_mem_data_cmd_i[ch_grant_id[1]];
  assign cce_mem_data_cmd_yumi_o = ch_yumi_oh[1];

  assign mem_data_resp_ready_o   = ch_resp_ready[0];
  assign cce_mem_data_resp_v_o   = ch_dest_v[0];
  assign mem_resp_ready_o        = ch_resp_ready[1];
  assign cce_mem_resp_v_o        = ch_dest_v[1];

  for (genvar i = 0; i < num_cce_p; i++) begin : g_bcast
    assign cce_mem_data_resp_o[i] = mem_data_resp_i;
    assign cce_mem_resp_o[i]      = mem_resp_i;
  end

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
module tb_bp_me_mem_arbiter;
  import bp_me_mem_arbiter_pkg::*;

  localparam int N       = 4;
  localparam int MAXO    = 4;
  localparam int LCE     = 1;
  localparam int ADDR    = 22;
  localparam int ASSOC   = 8;
  localparam int BLK     = 64;
  localparam int CMD_W   = cmd_width(LCE, ADDR, ASSOC);
  localparam int DCMD_W  = data_cmd_width(LCE, ADDR, ASSOC, BLK);
  localparam int RESP_W  = resp_width(LCE, ADDR, ASSOC);
  localparam int DRESP_W = data_resp_width(LCE, ADDR, ASSOC, BLK);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset_n;
  logic [N-1:0][CMD_W-1:0]       cce_cmd;
  logic [N-1:0]                  cce_cmd_v, cce_cmd_yumi;
  logic [N-1:0][DCMD_W-1:0]      cce_dcmd;
  logic [N-1:0]                  cce_dcmd_v, cce_dcmd_yumi;
  logic [CMD_W-1:0]              mem_cmd;
  logic                          mem_cmd_v, mem_cmd_yumi;
  logic [DCMD_W-1:0]             mem_dcmd;
  logic                          mem_dcmd_v, mem_dcmd_yumi;
  logic [DRESP_W-1:0]            mem_dresp;
  logic                          mem_dresp_v, mem_dresp_ready;
  logic [RESP_W-1:0]             mem_resp;
  logic                          mem_resp_v, mem_resp_ready;
  logic [N-1:0][DRESP_W-1:0]     cce_dresp;
  logic [N-1:0]                  cce_dresp_v, cce_dresp_ready;
  logic [N-1:0][RESP_W-1:0]      cce_resp;
  logic [N-1:0]                  cce_resp_v, cce_resp_ready;

  bp_me_mem_arbiter #(
    .num_cce_p(N), .num_lce_p(LCE), .addr_width_p(ADDR), .lce_assoc_p(ASSOC),
    .block_size_in_bytes_p(BLK), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i                     (clk),
    .reset_n_i                 (reset_n),
    .cce_mem_cmd_i             (cce_cmd),
    .cce_mem_cmd_v_i           (cce_cmd_v),
    .cce_mem_cmd_yumi_o        (cce_cmd_yumi),
    .cce_mem_data_cmd_i        (cce_dcmd),
    .cce_mem_data_cmd_v_i      (cce_dcmd_v),
    .cce_mem_data_cmd_yumi_o   (cce_dcmd_yumi),
    .mem_cmd_o                 (mem_cmd),
    .mem_cmd_v_o               (mem_cmd_v),
    .mem_cmd_yumi_i            (mem_cmd_yumi),
    .mem_data_cmd_o            (mem_dcmd),
    .mem_data_cmd_v_o          (mem_dcmd_v),
    .mem_data_cmd_yumi_i       (mem_dcmd_yumi),
    .mem_data_resp_i           (mem_dresp),
    .mem_data_resp_v_i         (mem_dresp_v),
    .mem_data_resp_ready_o     (mem_dresp_ready),
    .mem_resp_i                (mem_resp),
    .mem_resp_v_i              (mem_resp_v),
    .mem_resp_ready_o          (mem_resp_ready),
    .cce_mem_data_resp_o       (cce_dresp),
    .cce_mem_data_resp_v_o     (cce_dresp_v),
    .cce_mem_data_resp_ready_i (cce_dresp_ready),
    .cce_mem_resp_o            (cce_resp),
    .cce_mem_resp_v_o          (cce_resp_v),
    .cce_mem_resp_ready_i      (cce_resp_ready)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cce_cmd[i]  = CMD_W'(32'hA0 + i);
      cce_dcmd[i] = DCMD_W'(32'hC0 + i);
    end
    reset_n         = 1'b0;
    cce_cmd_v       = '1;
    cce_dcmd_v      = '1;
    mem_cmd_yumi    = 1'b1;
    mem_dcmd_yumi   = 1'b1;
    mem_dresp       = DRESP_W'(32'h55);
    mem_dresp_v     = 1'b1;
    mem_resp        = RESP_W'(32'h66);
    mem_resp_v      = 1'b1;
    cce_dresp_ready = '1;
    cce_resp_ready  = '1;

    // Reset held with every valid high
    tick(); tick();
    chk("rst_cmd_v",        mem_cmd_v, 0);
    chk("rst_dcmd_v",       mem_dcmd_v, 0);
    chk("rst_cmd_yumi",     cce_cmd_yumi, 0);
    chk("rst_dcmd_yumi",    cce_dcmd_yumi, 0);
    chk("rst_dresp_ready",  mem_dresp_ready, 0);
    chk("rst_resp_ready",   mem_resp_ready, 0);
    chk("rst_cce_dresp_v",  cce_dresp_v, 0);
    chk("rst_cce_resp_v",   cce_resp_v, 0);

    // Release; round-robin over all four with yumi every cycle, popping behind
    tick();
    reset_n       = 1'b1;
    mem_resp_v    = 1'b0;
    cce_dcmd_v    = '0;
    mem_dcmd_yumi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_dresp_v = (k >= 1);
      mem_dresp   = DRESP_W'(32'h100 + k);
      #1;
      chk("rr_cmd_v",  mem_cmd_v, 1);
      chk("rr_cmd",    mem_cmd[7:0], 8'hA0 + k % 4);
      chk("rr_yumi",   cce_cmd_yumi, 4'b0001 << (k % 4));
      if (k >= 1) begin
        chk("rr_dest_v", cce_dresp_v, 4'b0001 << ((k - 1) % 4));
        chk("rr_ready",  mem_dresp_ready, 1);
        chk("rr_bcast",  cce_dresp[2][15:0], 16'h100 + k);
      end
      tick();
    end
    cce_cmd_v    = '0;
    mem_cmd_yumi = 1'b0;
    mem_dresp_v  = 1'b1;
    #1;
    chk("rr_drain_v", cce_dresp_v, 4'b0001);
    tick();
    mem_dresp_v = 1'b0;

    // Lock: CCE2 granted, yumi low for 5 cycles while CCE0 also requests
    cce_cmd_v = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("lock_cmd",  mem_cmd[7:0], 8'hA2);
      chk("lock_yumi", cce_cmd_yumi, 0);
      tick();
      cce_cmd_v = 4'b0101;
    end
    mem_cmd_yumi = 1'b1;
    #1;
    chk("lock_cmd6",  mem_cmd[7:0], 8'hA2);
    chk("lock_yumi6", cce_cmd_yumi, 4'b0100);
    tick();
    #1;
    chk("unlock_cmd",  mem_cmd[7:0], 8'hA0);
    chk("unlock_yumi", cce_cmd_yumi, 4'b0001);
    tick();
    cce_cmd_v    = '0;
    mem_cmd_yumi = 1'b0;
    mem_dresp_v  = 1'b1;
    #1;
    chk("lock_route0", cce_dresp_v, 4'b0100);
    tick();
    #1;
    chk("lock_route1", cce_dresp_v, 4'b0001);
    tick();
    mem_dresp_v = 1'b0;

    // Backpressure: four reads fill the tag FIFO (pointer is at 1)
    cce_cmd_v    = '1;
    mem_cmd_yumi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_fill_yumi", cce_cmd_yumi, 4'b0001 << ((k + 1) % 4));
      tick();
    end
    #1;
    chk("bp_full_v",    mem_cmd_v, 0);
    chk("bp_full_yumi", cce_cmd_yumi, 0);
    tick();
    mem_dresp_v = 1'b1;
    #1;
    chk("bp_pop_cmd_v", mem_cmd_v, 0);
    chk("bp_pop_dest",  cce_dresp_v, 4'b0010);
    tick();
    mem_dresp_v = 1'b0;
    #1;
    chk("bp_5th_v",    mem_cmd_v, 1);
    chk("bp_5th_yumi", cce_cmd_yumi, 4'b0010);
    tick();
    cce_cmd_v    = '0;
    mem_cmd_yumi = 1'b0;
    mem_dresp_v  = 1'b1;
    #1; chk("bp_drain0", cce_dresp_v, 4'b0100); tick();
    #1; chk("bp_drain1", cce_dresp_v, 4'b1000); tick();
    #1; chk("bp_drain2", cce_dresp_v, 4'b0001); tick();
    #1; chk("bp_drain3", cce_dresp_v, 4'b0010); tick();
    mem_dresp_v = 1'b0;

    // Routing: reads from CCE1 then CCE3, CCE1 not ready at first
    cce_cmd_v    = 4'b0010;
    mem_cmd_yumi = 1'b1;
    #1; chk("route_yumi1", cce_cmd_yumi, 4'b0010); tick();
    cce_cmd_v = 4'b1000;
    #1; chk("route_yumi3", cce_cmd_yumi, 4'b1000); tick();
    cce_cmd_v       = '0;
    mem_cmd_yumi    = 1'b0;
    mem_dresp_v     = 1'b1;
    cce_dresp_ready = 4'b1101;
    #1;
    chk("route_dest1",    cce_dresp_v, 4'b0010);
    chk("route_notready", mem_dresp_ready, 0);
    tick();
    #1; chk("route_still_notready", mem_dresp_ready, 0); tick();
    cce_dresp_ready = '1;
    #1; chk("route_ready", mem_dresp_ready, 1); tick();
    #1;
    chk("route_dest3",  cce_dresp_v, 4'b1000);
    chk("route_ready3", mem_dresp_ready, 1);
    tick();
    mem_dresp_v = 1'b0;

    // Write channel: CCE0 stalled one cycle, then CCE3; acks routed in order
    cce_dcmd_v = 4'b1001;
    #1;
    chk("wr_v",    mem_dcmd_v, 1);
    chk("wr_cmd",  mem_dcmd[7:0], 8'hC0);
    chk("wr_yumi", cce_dcmd_yumi, 0);
    tick();
    mem_dcmd_yumi = 1'b1;
    #1; chk("wr_yumi0", cce_dcmd_yumi, 4'b0001); tick();
    #1; chk("wr_yumi3", cce_dcmd_yumi, 4'b1000); tick();
    cce_dcmd_v    = '0;
    mem_dcmd_yumi = 1'b0;
    mem_resp_v    = 1'b1;
    mem_resp      = RESP_W'(32'h77);
    #1;
    chk("wr_ack0",   cce_resp_v, 4'b0001);
    chk("wr_bcast",  cce_resp[1][15:0], 16'h0077);
    tick();
    #1; chk("wr_ack3", cce_resp_v, 4'b1000); tick();
    mem_resp_v = 1'b0;

    // Mid-operation reset with two reads outstanding (read pointer now at 0)
    cce_cmd_v    = 4'b0011;
    mem_cmd_yumi = 1'b1;
    #1; chk("mid_yumi0", cce_cmd_yumi, 4'b0001); tick();
    #1; chk("mid_yumi1", cce_cmd_yumi, 4'b0010); tick();
    cce_cmd_v    = '1;
    mem_cmd_yumi = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk("mid_rst_cmd_v", mem_cmd_v, 0);
    tick();
    reset_n     = 1'b1;
    cce_cmd_v   = '0;
    mem_dresp_v = 1'b1;
    #1;
    chk("stray_ready", mem_dresp_ready, 0);
    chk("stray_dest",  cce_dresp_v, 0);
    tick();
    #1;
    chk("stray_ready2", mem_dresp_ready, 0);
    tick();
    mem_dresp_v = 1'b0;
    cce_cmd_v   = '1;
    #1;
    chk("post_rst_grant", mem_cmd[7:0], 8'hA0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
